// File: rtl/read_fifo_pkg.sv
// Shared lane/field constants and FSM encodings for the
// MQ-coder lane FIFO bank (read and write sides).
package read_fifo_pkg;

  localparam int NLANE = 10;
  localparam int DW    = 8;
  localparam int CX_HI = 5;
  localparam int CX_LO = 1;
  localparam int D_BIT = 0;

  localparam logic [3:0] LAST_LANE = 4'd9;

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  function automatic logic [3:0] next_lane(
    input logic [3:0] p
  );
    return (p == LAST_LANE) ? 4'd0 : p + 4'd1;
  endfunction

endpackage

// File: rtl/cxd_skid_buf.sv
// Two-entry valid/ready buffer holding CX/D bytes
// between the lane mux and the MQ coder.
module cxd_skid_buf
  import read_fifo_pkg::*;
(
  input  logic          clk_dwt,
  input  logic          rst,
  input  logic          rst_syn,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          vld,
  output logic [1:0]    count
);

  logic [DW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign push_ok = push & (count != 2'd2);
  assign pop_ok  = pop & (count != 2'd0);
  assign dout    = mem[rd_ptr];
  assign vld     = (count != 2'd0);

  // Storage, pointers and occupancy; a push that
  // meets a pop leaves the count unchanged.
  always_ff @(posedge clk_dwt or negedge rst) begin
    if (!rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (rst_syn) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/read_fifo.sv
// Round-robin drain of the 10 lane FIFOs into the
// MQ coder, with code-block flush completion.
module read_fifo
  import read_fifo_pkg::*;
(
  input  logic          clk_dwt,
  input  logic          rst,
  input  logic          rst_syn,
  input  logic [DW-1:0] fifo_out0,
  input  logic [DW-1:0] fifo_out1,
  input  logic [DW-1:0] fifo_out2,
  input  logic [DW-1:0] fifo_out3,
  input  logic [DW-1:0] fifo_out4,
  input  logic [DW-1:0] fifo_out5,
  input  logic [DW-1:0] fifo_out6,
  input  logic [DW-1:0] fifo_out7,
  input  logic [DW-1:0] fifo_out8,
  input  logic [DW-1:0] fifo_out9,
  input  logic [9:0]    rdempty,
  output logic [9:0]    rdreq,
  input  logic          flush,
  input  logic          mq_ready,
  output logic [DW-1:0] cxd_out,
  output logic [4:0]    cx,
  output logic          d,
  output logic          cxd_vld,
  output logic          flush_done
);

  logic [DW-1:0]    lane [NLANE];
  logic [3:0]       rd_point;
  logic [3:0]       inflight_lane;
  logic             inflight;
  logic [1:0]       state;
  logic [1:0]       buf_count;
  logic [NLANE-1:0] sel;
  logic [DW-1:0]    lane_data;
  logic [2:0]       occ;
  logic             lane_empty;
  logic             run_ok;
  logic             pop;
  logic             issue;
  logic             drained;

  assign lane[0] = fifo_out0;
  assign lane[1] = fifo_out1;
  assign lane[2] = fifo_out2;
  assign lane[3] = fifo_out3;
  assign lane[4] = fifo_out4;
  assign lane[5] = fifo_out5;
  assign lane[6] = fifo_out6;
  assign lane[7] = fifo_out7;
  assign lane[8] = fifo_out8;
  assign lane[9] = fifo_out9;

  // Pointer decode for the request side and the
  // capture mux for the lane read last cycle.
  always_comb begin
    sel        = '0;
    lane_empty = 1'b1;
    lane_data  = '0;
    for (int i = 0; i < NLANE; i++) begin
      if (rd_point == i[3:0]) begin
        sel[i]     = 1'b1;
        lane_empty = rdempty[i];
      end
      if (inflight_lane == i[3:0]) begin
        lane_data = lane[i];
      end
    end
  end

  assign run_ok = rst & ~rst_syn;
  assign pop    = cxd_vld & mq_ready;
  assign occ    = {1'b0, buf_count}
                + {2'b00, inflight}
                - {2'b00, pop};
  assign issue  = run_ok
                & ~lane_empty
                & (occ < 3'd2)
                & (state != S_DONE);
  assign rdreq  = issue ? sel : '0;

  assign drained = (rdempty == 10'h3FF)
                 & ~inflight
                 & (buf_count == 2'd0);

  assign cx         = cxd_out[CX_HI:CX_LO];
  assign d          = cxd_out[D_BIT];
  assign flush_done = (state == S_DONE);

  // Lane pointer and one-deep read tracking; the
  // pointer survives flush to stay aligned with
  // the write side across code blocks.
  always_ff @(posedge clk_dwt or negedge rst) begin
    if (!rst) begin
      rd_point      <= 4'd0;
      inflight      <= 1'b0;
      inflight_lane <= 4'd0;
    end else if (rst_syn) begin
      rd_point      <= 4'd0;
      inflight      <= 1'b0;
      inflight_lane <= 4'd0;
    end else begin
      inflight      <= issue;
      inflight_lane <= rd_point;
      if (issue) begin
        rd_point <= next_lane(rd_point);
      end
    end
  end

  // Flush sequencing: drain everything, then hold
  // done until flush is withdrawn.
  always_ff @(posedge clk_dwt or negedge rst) begin
    if (!rst) begin
      state <= S_RUN;
    end else if (rst_syn) begin
      state <= S_RUN;
    end else begin
      case (state)
        S_RUN: begin
          if (flush) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!flush)       state <= S_RUN;
          else if (drained) state <= S_DONE;
        end
        S_DONE: begin
          if (!flush) state <= S_RUN;
        end
        default: state <= S_RUN;
      endcase
    end
  end

  cxd_skid_buf u_buf (
    .clk_dwt (clk_dwt),
    .rst     (rst),
    .rst_syn (rst_syn),
    .push    (inflight),
    .din     (lane_data),
    .pop     (pop),
    .dout    (cxd_out),
    .vld     (cxd_vld),
    .count   (buf_count)
  );

endmodule

// File: tb/tb_read_fifo.sv
// Scoreboard bench for read_fifo: lane FIFO model,
// directed stimulus, decoupled output monitor.
module tb_read_fifo;
  import read_fifo_pkg::*;

  logic       clk_dwt = 1'b0;
  logic       rst = 1'b0;
  logic       rst_syn = 1'b0;
  logic [7:0] fo [10];
  logic [9:0] rdempty = 10'h3FF;
  logic [9:0] rdreq;
  logic       flush = 1'b0;
  logic       mq_ready = 1'b1;
  logic [7:0] cxd_out;
  logic [4:0] cx;
  logic       d;
  logic       cxd_vld;
  logic       flush_done;

  logic [7:0] lq [10][$];
  logic [7:0] exp_q [$];
  logic [9:0] wmask = '0;
  logic [7:0] wdat [10];
  logic       wr_en = 1'b0;

  int checks = 0;
  int errors = 0;
  int peak = 0;
  bit hold_pend = 0;
  logic [7:0] held = '0;

  always #5 clk_dwt = ~clk_dwt;

  read_fifo dut (
    .clk_dwt    (clk_dwt),
    .rst        (rst),
    .rst_syn    (rst_syn),
    .fifo_out0  (fo[0]),
    .fifo_out1  (fo[1]),
    .fifo_out2  (fo[2]),
    .fifo_out3  (fo[3]),
    .fifo_out4  (fo[4]),
    .fifo_out5  (fo[5]),
    .fifo_out6  (fo[6]),
    .fifo_out7  (fo[7]),
    .fifo_out8  (fo[8]),
    .fifo_out9  (fo[9]),
    .rdempty    (rdempty),
    .rdreq      (rdreq),
    .flush      (flush),
    .mq_ready   (mq_ready),
    .cxd_out    (cxd_out),
    .cx         (cx),
    .d          (d),
    .cxd_vld    (cxd_vld),
    .flush_done (flush_done)
  );

  task automatic chk(input string name,
                     input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h",
               name, act, exp);
    end
  endtask

  // Lane FIFO model: normal mode, q valid one
  // cycle after rdreq; writes land in the same edge.
  always @(posedge clk_dwt) begin
    for (int i = 0; i < 10; i++) begin
      if (rdreq[i] && lq[i].size() > 0)
        fo[i] <= lq[i].pop_front();
      if (wr_en && wmask[i])
        lq[i].push_back(wdat[i]);
      rdempty[i] <= (lq[i].size() == 0);
    end
  end

  // Output monitor / scoreboard
  always @(negedge clk_dwt) begin
    if (rst && !rst_syn) begin
      if (int'(dut.buf_count) > peak)
        peak = int'(dut.buf_count);
      if (dut.inflight && dut.buf_count == 2'd2) begin
        errors++;
        $display("FAIL push_on_full: count=2 inflight=1");
      end
      if (hold_pend && cxd_vld)
        chk("hold_stable", cxd_out, held);
      hold_pend = cxd_vld && !mq_ready;
      held = cxd_out;
      if (cxd_vld && mq_ready) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_byte: got 0x%0h want none",
                   cxd_out);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          chk("cxd_out", cxd_out, e);
          chk("cx", cx, e[5:1]);
          chk("d", d, e[0]);
        end
      end
    end else begin
      hold_pend = 0;
    end
  end

  task automatic tick();
    @(posedge clk_dwt);
    #1;
  endtask

  task automatic put(input int lane,
                     input logic [7:0] v,
                     input bit expect_it);
    wmask[lane] = 1'b1;
    wdat[lane]  = v;
    if (expect_it) exp_q.push_back(v);
  endtask

  task automatic commit();
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    wmask = '0;
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk_dwt);
      if (!cxd_vld && !dut.inflight &&
          rdempty == 10'h3FF)
        done = 1;
    end
    chk({name, "_drained"}, int'(done), 1);
    chk({name, "_exp_left"}, exp_q.size(), 0);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: no finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    for (int i = 0; i < 10; i++) begin
      fo[i]   = '0;
      wdat[i] = '0;
    end
    repeat (3) tick();
    rst = 1'b1;
    tick();
    @(negedge clk_dwt);
    chk("rst_vld", cxd_vld, 0);
    chk("rst_rdreq", rdreq, 0);
    chk("rst_done", flush_done, 0);
    chk("rst_out", cxd_out, 0);
    chk("rst_ptr", dut.rd_point, 0);
    chk("rst_state", dut.state, S_RUN);
    tick();

    // basic in-order drain, lanes 0..4
    put(0, 8'h02, 1); put(1, 8'h04, 1);
    put(2, 8'h06, 1); put(3, 8'h08, 1);
    put(4, 8'h0A, 1);
    commit();
    @(negedge clk_dwt);
    chk("c0_rdreq", rdreq, 10'h001);
    chk("c0_vld", cxd_vld, 0);
    @(negedge clk_dwt);
    chk("c1_rdreq", rdreq, 10'h002);
    chk("c1_vld", cxd_vld, 0);
    @(negedge clk_dwt);
    chk("c2_rdreq", rdreq, 10'h004);
    chk("c2_vld", cxd_vld, 1);
    @(negedge clk_dwt);
    chk("c3_rdreq", rdreq, 10'h008);
    @(negedge clk_dwt);
    chk("c4_rdreq", rdreq, 10'h010);
    wait_drain("basic");
    chk("basic_ptr", dut.rd_point, 5);

    // advance to 8, then wrap through 9 -> 0
    put(5, 8'h55, 1); put(6, 8'h56, 1);
    put(7, 8'h57, 1);
    commit();
    wait_drain("adv");
    chk("adv_ptr", dut.rd_point, 8);
    put(8, 8'h11, 1); put(9, 8'h22, 1);
    put(0, 8'h33, 1);
    commit();
    wait_drain("wrap");
    chk("wrap_ptr", dut.rd_point, 1);

    // backpressure with 6 bytes queued
    mq_ready = 1'b0;
    peak = 0;
    for (int i = 1; i <= 6; i++)
      put(i, 8'h60 + 8'(i), 1);
    commit();
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk_dwt);
      if (cxd_vld) seen = 1;
    end
    chk("bp_first_vld", int'(seen), 1);
    repeat (4) @(posedge clk_dwt);
    #1;
    chk("bp_peak", peak, 2);
    chk("bp_head", cxd_out, 8'h61);
    mq_ready = 1'b1;
    wait_drain("bp");
    chk("bp_ptr", dut.rd_point, 7);

    // move pointer to 3
    put(7, 8'h77, 1); put(8, 8'h78, 1);
    put(9, 8'h79, 1); put(0, 8'h70, 1);
    put(1, 8'h71, 1); put(2, 8'h72, 1);
    commit();
    wait_drain("pre");
    chk("pre_ptr", dut.rd_point, 3);

    // ordering stall: lane 4 full, lane 3 empty
    exp_q.push_back(8'h36);
    exp_q.push_back(8'h44);
    put(4, 8'h44, 0);
    commit();
    for (int n = 0; n < 4; n++) begin
      @(negedge clk_dwt);
      chk("stall_rdreq", rdreq, 0);
    end
    tick();
    put(3, 8'h36, 0);
    commit();
    @(negedge clk_dwt);
    chk("stall_l3", rdreq, 10'h008);
    @(negedge clk_dwt);
    chk("stall_l4", rdreq, 10'h010);
    wait_drain("stall");

    // flush with 3 pending bytes
    put(5, 8'h75, 1); put(6, 8'h76, 1);
    put(7, 8'h7F, 1);
    flush = 1'b1;
    commit();
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk_dwt);
      if (cxd_vld && mq_ready && cxd_out == 8'h7F)
        seen = 1;
      else
        chk("fl_not_done", flush_done, 0);
    end
    chk("fl_last_seen", int'(seen), 1);
    chk("fl_done_pop", flush_done, 0);
    @(negedge clk_dwt);
    chk("fl_done_gap", flush_done, 0);
    @(negedge clk_dwt);
    chk("fl_done_rise", flush_done, 1);
    @(negedge clk_dwt);
    chk("fl_done_hold", flush_done, 1);
    chk("fl_no_rdreq", rdreq, 0);
    tick();
    flush = 1'b0;
    @(negedge clk_dwt);
    chk("fl_done_reg", flush_done, 1);
    @(negedge clk_dwt);
    chk("fl_done_drop", flush_done, 0);
    chk("fl_state", dut.state, S_RUN);
    chk("fl_ptr", dut.rd_point, 8);
    tick();

    // synchronous clear with two bytes buffered
    mq_ready = 1'b0;
    put(8, 8'hA8, 0); put(9, 8'hA9, 0);
    commit();
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk_dwt);
      if (dut.buf_count == 2'd2) seen = 1;
    end
    chk("rs_full", int'(seen), 1);
    tick();
    rst_syn = 1'b1;
    @(negedge clk_dwt);
    chk("rs_rdreq", rdreq, 0);
    tick();
    rst_syn = 1'b0;
    @(negedge clk_dwt);
    chk("rs_vld", cxd_vld, 0);
    chk("rs_ptr", dut.rd_point, 0);
    chk("rs_state", dut.state, S_RUN);
    chk("rs_out", cxd_out, 0);
    mq_ready = 1'b1;
    tick();
    chk("end_exp_left", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
